// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and segment constants for the seven-segment scan scheduler
package ssd_pkg;
    typedef logic [1:0] digit_idx_t;
    typedef enum logic {BLANK, SHOW} phase_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/ssd_scan_sched_seg_encoder.sv
// ssd_seg_encoder: combinational hex to active-low {g,f,e,d,c,b,a} segment lookup
module ssd_seg_encoder
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/ssd_scan_sched.sv
// ssd_scan_sched: 4-digit seven-segment scan scheduler with tear-free writes; SSD_LZ_BLANK_EN adds leading-zero suppression
module ssd_scan_sched
    import ssd_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = $clog2(DIGIT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_idx,
    input  logic [3:0] wr_data,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       a4,
    output logic [6:0] c,
    output logic       frame_done
);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt, cnt_n;
    digit_idx_t       cur_idx;
    phase_t           phase, phase_n;
    logic [3:0]       digit [4];
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             wrap;
    logic             hide;

    assign wrap     = cnt == CNT_LAST;
    assign wr_ready = rst & ~(phase == SHOW && wr_idx == cur_idx);
    assign {a4, a3, a2, a1} = an;

    // next slot position and the phase it lands in
    always_comb begin
        cnt_n   = wrap ? '0 : cnt + 1'b1;
        phase_n = cnt_n < CNT_BLANK ? BLANK : SHOW;
    end

    // slot counter, phase state and digit advance on wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            cur_idx <= '0;
            phase   <= BLANK;
        end else begin
            cnt   <= cnt_n;
            phase <= phase_n;
            if (wrap) cur_idx <= cur_idx + 2'd1;
        end
    end

    // digit registers; the lit digit is only writable once its blank window opens
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) digit[k] <= '0;
        end else if (wr_valid && wr_ready) begin
            digit[wr_idx] <= wr_data;
        end
    end

    ssd_seg_encoder u_enc (
        .hex (digit[cur_idx]),
        .seg (seg)
    );

`ifdef SSD_LZ_BLANK_EN
    logic [3:0] lz;
    // a digit is suppressed when it and every higher digit are zero; digit 0 always shows
    always_comb begin
        lz    = '0;
        lz[3] = digit[3] == 4'd0;
        lz[2] = lz[3] && digit[2] == 4'd0;
        lz[1] = lz[2] && digit[1] == 4'd0;
    end
    assign hide = lz[cur_idx];
`else
    assign hide = 1'b0;
`endif

    // registered display drive and frame pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            an         <= 4'hF;
            c          <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an         <= phase == SHOW ? ~(4'b1 << cur_idx) : 4'hF;
            c          <= (phase == SHOW && !hide) ? seg : SEG_BLANK;
            frame_done <= wrap && cur_idx == 2'd3;
        end
    end
endmodule

// File: tb/tb_ssd_scan_sched.sv
// tb_ssd_scan_sched: randomized self-checking bench for ssd_scan_sched against a time-position reference model
module tb_ssd_scan_sched;
    localparam int DC = 8;
    localparam int BC = 2;

    logic       clk = 0;
    logic       rst = 0;
    logic       wr_valid = 0;
    logic       wr_ready;
    logic [1:0] wr_idx = 0;
    logic [3:0] wr_data = 0;
    logic       a1, a2, a3, a4;
    logic [6:0] c;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         pos = 0;
    logic [3:0] digs [4];
    logic [3:0] exp_an;
    logic [6:0] exp_c;
    logic       exp_fd;
    bit         primed = 0;
    bit         acc = 0;

    always #5 clk = ~clk;

    ssd_scan_sched #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .a4         (a4),
        .c          (c),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hidden(int k);
`ifdef SSD_LZ_BLANK_EN
        if (k == 0) return 0;
        for (int j = k; j < 4; j++) if (digs[j] != 0) return 0;
        return 1;
`else
        return k < 0;
`endif
    endfunction

    // one clock: check outputs, drive inputs, check ready, predict the edge
    task automatic tick(input logic r, input logic v, input logic [1:0] i, input logic [3:0] d);
        int off, idx;
        bit rdy, show;
        if (primed) begin
            check("anodes", {a4, a3, a2, a1}, exp_an);
            check("cathodes", c, exp_c);
            check("frame_done", frame_done, exp_fd);
        end
        rst = r; wr_valid = v; wr_idx = i; wr_data = d;
        off = pos % DC;
        idx = (pos / DC) % 4;
        rdy = r && !(off >= BC && int'(i) == idx);
        #1 check("wr_ready", wr_ready, rdy);
        acc = v && rdy;
        if (!r) begin
            pos = 0;
            for (int k = 0; k < 4; k++) digs[k] = 0;
            exp_an = 4'hF; exp_c = 7'h7F; exp_fd = 0;
        end else begin
            show   = off >= BC;
            exp_an = show ? ~(4'b1 << idx) : 4'hF;
            exp_c  = (show && !hidden(idx)) ? seg_ref[digs[idx]] : 7'h7F;
            exp_fd = (pos % (4 * DC)) == 4 * DC - 1;
            if (acc) digs[i] = d;
            pos++;
        end
        @(posedge clk);
        @(negedge clk);
        primed = 1;
    endtask

    task automatic put(input logic [1:0] i, input logic [3:0] d, output int stall);
        stall = 0;
        tick(1, 1, i, d);
        while (!acc && stall < 20) begin
            stall++;
            tick(1, 1, i, d);
        end
        check("put_accept", acc, 1);
    endtask

    task automatic wait_slot(input int idx, input int off);
        for (int k = 0; k < 64 && !((pos % DC) == off && ((pos / DC) % 4) == idx); k++) tick(1, 0, 0, 0);
    endtask

    initial begin
        int s, first, stall;
        bit pend;
        logic [1:0] pi;
        logic [3:0] pd;
        logic r;
        first = 0;
        repeat (3) tick(0, 0, 0, 0);
        check("reset_dark", {a4, a3, a2, a1, c}, {4'hF, 7'h7F});
        for (int k = 1; k <= 40; k++) begin
            tick(1, 0, 0, 0);
            if (k == 2) check("pre_show", {a4, a3, a2, a1, c}, {4'hF, 7'h7F});
            if (k == 3) check("first_show", {a4, a3, a2, a1, c}, {4'b1110, 7'h40});
            if (frame_done && first == 0) first = k;
        end
        check("first_frame", first, 32);
        put(0, 4'h1, s); put(1, 4'h2, s); put(2, 4'h3, s); put(3, 4'h8, s);
        repeat (40) tick(1, 0, 0, 0);
        wait_slot(2, 3);
        put(2, 4'hA, s);
        check("tear_stall", s, 5);
        wait_slot(0, 4);
        put(3, 4'hF, s);
        check("concurrent_stall", s, 0);
        repeat (40) tick(1, 0, 0, 0);
        wait_slot(2, 4);
        tick(0, 1, 2, 4'h5);
        check("midscan_dark", {a4, a3, a2, a1, c}, {4'hF, 7'h7F});
        repeat (40) tick(1, 0, 0, 0);
        put(3, 4'h0, s); put(2, 4'h0, s); put(1, 4'h5, s); put(0, 4'h0, s);
        repeat (40) tick(1, 0, 0, 0);
        pend = 0; stall = 0; pi = 0; pd = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!pend && $urandom_range(2) == 0) begin
                pend = 1; stall = 0;
                pi = 2'($urandom_range(3));
                pd = 4'($urandom_range(15));
            end
            r = $urandom_range(199) != 0;
            tick(r, pend, pi, pd);
            if (!r) pend = 0;
            else if (pend && acc) begin
                check("stall_bound", stall <= DC - BC, 1);
                pend = 0;
            end else if (pend) stall++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
